noekeon_iter_core: RTL and testbench

- Sequential, parametrised Noekeon-128 block cipher core. It performs both encryption and decryption in direct-key mode.
- The full round function is instantiated ROUNDS_PER_CYCLE times and reused over 16/ROUNDS_PER_CYCLE cycles.
- Valid/ready handshakes on both input and output.
- Sits between the key/data loader and the output buffer; this is the first complete cipher core built on the round-function block.

---
 rtl/noekeon_iter_core.sv | 235 +++++++++++++++++++++++
 tb/tb_noekeon_iter_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noekeon_iter_core.sv
// Iterative Noekeon-128 cipher core (direct key), ROUNDS_PER_CYCLE rounds per clock.
// Define NOEKEON_INDIRECT_KEY_EN to add inIndirect and the KEYGEN state.
module noekeon_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         inClk,
    input  logic         inRstN,
    input  logic         inValid,
    output logic         inReady,
    input  logic         inDecrypt,
`ifdef NOEKEON_INDIRECT_KEY_EN
    input  logic         inIndirect,
`endif
    input  logic [127:0] inDataKey,
    input  logic [127:0] inDataState,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outDataState,
    output logic         outBusy
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8 &&
        ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

`ifdef NOEKEON_INDIRECT_KEY_EN
    typedef enum logic [1:0] {IDLE, ROUND, DONE, KEYGEN} state_t;
`else
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
`endif

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [7:0] rc(input logic [4:0] i);
        logic [7:0] v;
        case (i)
            5'd0:    v = 8'h80;
            5'd1:    v = 8'h1B;
            5'd2:    v = 8'h36;
            5'd3:    v = 8'h6C;
            5'd4:    v = 8'hD8;
            5'd5:    v = 8'hAB;
            5'd6:    v = 8'h4D;
            5'd7:    v = 8'h9A;
            5'd8:    v = 8'h2F;
            5'd9:    v = 8'h5E;
            5'd10:   v = 8'hBC;
            5'd11:   v = 8'h63;
            5'd12:   v = 8'hC6;
            5'd13:   v = 8'h97;
            5'd14:   v = 8'h35;
            5'd15:   v = 8'h6A;
            5'd16:   v = 8'hD4;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [127:0] theta(input logic [127:0] k,
                                           input logic [127:0] a);
        logic [31:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = a;
        t  = a0 ^ a2;
        t  = t ^ rotl(t, 8) ^ rotl(t, 24);
        a1 = a1 ^ t;
        a3 = a3 ^ t;
        {a0, a1, a2, a3} = {a0, a1, a2, a3} ^ k;
        t  = a1 ^ a3;
        t  = t ^ rotl(t, 8) ^ rotl(t, 24);
        a0 = a0 ^ t;
        a2 = a2 ^ t;
        return {a0, a1, a2, a3};
    endfunction

    function automatic logic [127:0] gamma(input logic [127:0] a);
        logic [31:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = a;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        t  = a3;
        a3 = a0;
        a0 = t;
        a2 = a2 ^ a0 ^ a1 ^ a3;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        return {a0, a1, a2, a3};
    endfunction

    function automatic logic [127:0] round(input logic [127:0] k,
                                           input logic [127:0] a,
                                           input logic [7:0]   c1,
                                           input logic [7:0]   c2);
        logic [127:0] s;
        logic [31:0]  a0, a1, a2, a3;
        s = theta(k, a ^ {24'h0, c1, 96'h0});
        s = s ^ {24'h0, c2, 96'h0};
        {a0, a1, a2, a3} = s;
        s = gamma({a0, rotl(a1, 1), rotl(a2, 5), rotl(a3, 2)});
        {a0, a1, a2, a3} = s;
        return {a0, rotl(a1, 31), rotl(a2, 27), rotl(a3, 30)};
    endfunction

    state_t       state;
    logic [4:0]   cnt;
    logic [127:0] st;
    logic [127:0] wk;
    logic         dec;
    logic         ready_q;
    logic         valid_q;
    logic         busy_q;
    logic [127:0] out_q;

    logic [127:0] x;
    logic [127:0] nxt;
    logic [127:0] rkey;
    logic         enc;
    logic [4:0]   idx;
    logic         last;

    assign last = (cnt + STEP) == 5'd16;

    // KEYGEN reuses the round datapath: encrypt under the null key
    always_comb begin
        rkey = wk;
        enc  = !dec;
        idx  = '0;
`ifdef NOEKEON_INDIRECT_KEY_EN
        if (state == KEYGEN) begin
            rkey = '0;
            enc  = 1'b1;
        end
`endif
        x = st;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            idx = cnt + 5'(j);
            x = round(rkey, x,
                      enc ? rc(idx) : 8'h00,
                      enc ? 8'h00 : rc(5'd16 - idx));
        end
        if (last) begin
            if (enc) begin
                x = theta(rkey, x ^ {24'h0, rc(5'd16), 96'h0});
            end else begin
                x = theta(rkey, x) ^ {24'h0, rc(5'd0), 96'h0};
            end
        end
        nxt = x;
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state   <= IDLE;
            cnt     <= '0;
            st      <= '0;
            wk      <= '0;
            dec     <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inValid) begin
                        dec     <= inDecrypt;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        st      <= inDataState;
                        wk      <= inDecrypt ? theta('0, inDataKey) : inDataKey;
                        state   <= ROUND;
`ifdef NOEKEON_INDIRECT_KEY_EN
                        // key runs through the datapath; data parks in wk
                        if (inIndirect) begin
                            st    <= inDataKey;
                            wk    <= inDataState;
                            state <= KEYGEN;
                        end
`endif
                    end
                end
`ifdef NOEKEON_INDIRECT_KEY_EN
                KEYGEN: begin
                    if (last) begin
                        st    <= wk;
                        wk    <= dec ? theta('0, nxt) : nxt;
                        cnt   <= '0;
                        state <= ROUND;
                    end else begin
                        st  <= nxt;
                        cnt <= cnt + STEP;
                    end
                end
`endif
                ROUND: begin
                    st <= nxt;
                    if (last) begin
                        cnt     <= '0;
                        out_q   <= nxt;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + STEP;
                    end
                end
                DONE: begin
                    if (outReady) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign inReady      = ready_q;
    assign outValid     = valid_q;
    assign outBusy      = busy_q;
    assign outDataState = out_q;

endmodule

// File: tb/tb_noekeon_iter_core.sv
// Bench for noekeon_iter_core: all five legal ROUNDS_PER_CYCLE instances driven in lockstep,
// checked against known vectors and a word-level Noekeon model.
`timescale 1ns/1ps
module tb_noekeon_iter_core;

    localparam int NI = 5;
    localparam bit [7:0] RCT [17] = '{
        8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
        8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_dec = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_key = '0;
    logic [127:0] in_data = '0;
`ifdef NOEKEON_INDIRECT_KEY_EN
    logic         in_ind = 1'b0;
`endif

    logic         rdy [NI];
    logic         ov  [NI];
    logic         bsy [NI];
    logic [127:0] od  [NI];

    int n_chk = 0;
    int n_pass = 0;

    bit [31:0] m_a [4];
    bit [31:0] m_k [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        noekeon_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .inClk       (clk),
            .inRstN      (rst_n),
            .inValid     (in_valid),
            .inReady     (rdy[g]),
            .inDecrypt   (in_dec),
`ifdef NOEKEON_INDIRECT_KEY_EN
            .inIndirect  (in_ind),
`endif
            .inDataKey   (in_key),
            .inDataState (in_data),
            .outValid    (ov[g]),
            .outReady    (out_ready),
            .outDataState(od[g]),
            .outBusy     (bsy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    function automatic bit [31:0] rl(input bit [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic m_theta();
        bit [31:0] t;
        t = m_a[0] ^ m_a[2];
        t ^= rl(t, 8) ^ rl(t, 24);
        m_a[1] ^= t;
        m_a[3] ^= t;
        for (int i = 0; i < 4; i++) m_a[i] ^= m_k[i];
        t = m_a[1] ^ m_a[3];
        t ^= rl(t, 8) ^ rl(t, 24);
        m_a[0] ^= t;
        m_a[2] ^= t;
    endtask

    task automatic m_gamma();
        bit [31:0] t;
        m_a[1] ^= ~m_a[3] & ~m_a[2];
        m_a[0] ^= m_a[2] & m_a[1];
        t = m_a[3];
        m_a[3] = m_a[0];
        m_a[0] = t;
        m_a[2] ^= m_a[0] ^ m_a[1] ^ m_a[3];
        m_a[1] ^= ~m_a[3] & ~m_a[2];
        m_a[0] ^= m_a[2] & m_a[1];
    endtask

    task automatic m_round(input bit [7:0] c1, input bit [7:0] c2);
        m_a[0] ^= {24'h0, c1};
        m_theta();
        m_a[0] ^= {24'h0, c2};
        m_a[1] = rl(m_a[1], 1);
        m_a[2] = rl(m_a[2], 5);
        m_a[3] = rl(m_a[3], 2);
        m_gamma();
        m_a[1] = rl(m_a[1], 31);
        m_a[2] = rl(m_a[2], 27);
        m_a[3] = rl(m_a[3], 30);
    endtask

    task automatic ref_cipher(input logic [127:0] key, input logic [127:0] din,
                              input logic dec, output logic [127:0] res);
        for (int i = 0; i < 4; i++) m_k[i] = key[127-32*i -: 32];
        if (dec) begin
            for (int i = 0; i < 4; i++) begin
                m_a[i] = m_k[i];
                m_k[i] = '0;
            end
            m_theta();
            for (int i = 0; i < 4; i++) m_k[i] = m_a[i];
        end
        for (int i = 0; i < 4; i++) m_a[i] = din[127-32*i -: 32];
        if (dec) begin
            for (int r = 16; r >= 1; r--) m_round(8'h00, RCT[r]);
            m_theta();
            m_a[0] ^= {24'h0, RCT[0]};
        end else begin
            for (int r = 0; r < 16; r++) m_round(RCT[r], 8'h00);
            m_a[0] ^= {24'h0, RCT[16]};
            m_theta();
        end
        res = {m_a[0], m_a[1], m_a[2], m_a[3]};
    endtask

    task automatic run(input logic [127:0] key, input logic [127:0] data,
                       input logic dec, input logic ind,
                       input logic [127:0] exp, input int hold);
        int lat [NI];
        logic [127:0] junk;
        @(negedge clk);
        for (int g = 0; g < NI; g++)
            check($sformatf("ready r%0d", 1 << g), 128'(rdy[g]), 128'd1);
        in_valid = 1'b1;
        in_key   = key;
        in_data  = data;
        in_dec   = dec;
`ifdef NOEKEON_INDIRECT_KEY_EN
        in_ind   = ind;
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_key   = rnd128();
        in_data  = rnd128();
        in_dec   = ~dec;
        for (int g = 0; g < NI; g++) begin
            lat[g] = 0;
            check($sformatf("busy r%0d", 1 << g), 128'(bsy[g]), 128'd1);
        end
        for (int e = 1; e <= 40; e++) begin
            bit all;
            @(posedge clk);
            @(negedge clk);
            all = 1'b1;
            for (int g = 0; g < NI; g++) begin
                if (ov[g] && lat[g] == 0) lat[g] = e;
                if (lat[g] == 0) all = 1'b0;
            end
            if (all) break;
        end
        for (int g = 0; g < NI; g++) begin
            check($sformatf("latency r%0d", 1 << g), 128'(lat[g]),
                  128'((ind ? 2 : 1) * (16 >> g)));
            check($sformatf("data r%0d", 1 << g), od[g], exp);
            check($sformatf("valid r%0d", 1 << g), 128'(ov[g]), 128'd1);
        end
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'($urandom % 2);
            junk = rnd128();
            in_data = junk;
            @(posedge clk);
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                check($sformatf("hold valid r%0d", 1 << g), 128'(ov[g]), 128'd1);
                check($sformatf("hold data r%0d", 1 << g), od[g], exp);
                check($sformatf("hold ready r%0d", 1 << g), 128'(rdy[g]), 128'd0);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("post valid r%0d", 1 << g), 128'(ov[g]), 128'd0);
            check($sformatf("post ready r%0d", 1 << g), 128'(rdy[g]), 128'd1);
            check($sformatf("post busy r%0d", 1 << g), 128'(bsy[g]), 128'd0);
        end
    endtask

    task automatic reset_mid_op();
        bit seen;
        @(negedge clk);
        in_valid = 1'b1;
        in_key   = rnd128();
        in_data  = rnd128();
        in_dec   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst valid r%0d", 1 << g), 128'(ov[g]), 128'd0);
            check($sformatf("rst data r%0d", 1 << g), od[g], 128'd0);
            check($sformatf("rst ready r%0d", 1 << g), 128'(rdy[g]), 128'd1);
        end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            for (int g = 0; g < NI; g++) if (ov[g]) seen = 1'b1;
        end
        check("rst no pulse", 128'(seen), 128'd0);
    endtask

    initial begin
        logic [127:0] k, d, e, w;
        logic         dr;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("reset valid r%0d", 1 << g), 128'(ov[g]), 128'd0);
            check($sformatf("reset data r%0d", 1 << g), od[g], 128'd0);
            check($sformatf("reset busy r%0d", 1 << g), 128'(bsy[g]), 128'd0);
            check($sformatf("reset ready r%0d", 1 << g), 128'(rdy[g]), 128'd1);
        end
        rst_n = 1'b1;

        run(128'h0, 128'h0, 1'b0, 1'b0,
            128'hb1656851699e29fa24b70148503d2dfc, 0);
        run({128{1'b1}}, {128{1'b1}}, 1'b0, 1'b0,
            128'h2a78421b87c7d0924f26113f1d1349b2, 0);
        run(128'hb1656851699e29fa24b70148503d2dfc,
            128'h2a78421b87c7d0924f26113f1d1349b2, 1'b0, 1'b0,
            128'he2f687e07b75660ffc372233bc47532c, 0);
        run(128'hb1656851699e29fa24b70148503d2dfc,
            128'he2f687e07b75660ffc372233bc47532c, 1'b1, 1'b0,
            128'h2a78421b87c7d0924f26113f1d1349b2, 20);

        reset_mid_op();

        for (int t = 0; t < 6; t++) begin
            k  = rnd128();
            d  = rnd128();
            dr = 1'($urandom % 2);
            ref_cipher(k, d, dr, e);
            run(k, d, dr, 1'b0, e, 0);
        end

`ifdef NOEKEON_INDIRECT_KEY_EN
        run(128'h0, 128'h2a78421b87c7d0924f26113f1d1349b2, 1'b0, 1'b1,
            128'he2f687e07b75660ffc372233bc47532c, 0);
        for (int t = 0; t < 2; t++) begin
            k  = rnd128();
            d  = rnd128();
            dr = 1'(t);
            ref_cipher(128'h0, k, 1'b0, w);
            ref_cipher(w, d, dr, e);
            run(k, d, dr, 1'b1, e, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
